scrachpad_banked_stream: RTL and testbench

Parametrised successor to the single-section matrix scratchpad. It holds SPN banks of ELEM_NUM words, each BW bits wide. Provides:
- a lane-masked write port
- a registered single-word bus read port
- a valid/ready streaming readout of a whole bank
- a background bank-clear engine

It sits between the bus slave and the systolic-array loader, which consumes operand matrices row-word by row-word through the stream port.

---
 rtl/scrachpad_banked_stream.sv | 148 ++++++++++++++
 tb/tb_scrachpad_banked_stream.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scrachpad_banked_stream.sv
// SPN-bank scratchpad: lane-masked writes, registered bus reads, bank stream-out and bank clear.
// Build option SP_RD_BYPASS_EN: a bus read hitting a same-cycle write returns the merged new word.
module scrachpad_banked_stream #(
  parameter int DW       = 8,
  parameter int BW       = 32,
  parameter int MAX_DIM  = BW / DW,
  parameter int SPN      = 4,
  parameter int ELEM_NUM = MAX_DIM * MAX_DIM,
  parameter int ADDR_W   = $clog2(ELEM_NUM),
  parameter int BANK_W   = (SPN > 1) ? $clog2(SPN) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              wr_en_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [MAX_DIM-1:0] wr_strb_i,
  input  logic [BW-1:0]     wr_data_i,
  input  logic              rd_req_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [BW-1:0]     rd_data_o,
  output logic              rd_valid_o,
  input  logic              strm_start_i,
  input  logic [BANK_W-1:0] strm_bank_i,
  output logic [BW-1:0]     strm_data_o,
  output logic              strm_valid_o,
  input  logic              strm_ready_i,
  output logic              strm_last_o,
  input  logic              clr_start_i,
  input  logic [BANK_W-1:0] clr_bank_i,
  output logic              busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_STRM = 2'd1;
  localparam logic [1:0] S_CLR  = 2'd2;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ELEM_NUM - 1);
  localparam logic [ADDR_W-1:0] ZERO = '0;

  logic [BW-1:0] mem_q [SPN][ELEM_NUM];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [BW-1:0]     sdata_q, sdata_d;
  logic [BW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q;

  logic          wr_ok;
  logic [BW-1:0] wr_old, wr_new, rd_word;

  function automatic logic bank_ok(input logic [BANK_W-1:0] b);
    return int'(b) < SPN;
  endfunction

  assign wr_old  = mem_q[wr_bank_i][wr_addr_i];
  assign cnt_nxt = cnt_q + 1'b1;

  always_comb begin
    wr_new = wr_old;
    for (int k = 0; k < MAX_DIM; k++) begin
      if (wr_strb_i[k]) wr_new[k*DW +: DW] = wr_data_i[k*DW +: DW];
    end
  end

  // The bank under clear is locked against bus writes
  assign wr_ok = wr_en_i && bank_ok(wr_bank_i)
              && !(state_q == S_CLR && wr_bank_i == bank_q);

`ifdef SP_RD_BYPASS_EN
  assign rd_word = (wr_ok && wr_bank_i == rd_bank_i
                    && wr_addr_i == rd_addr_i)
                 ? wr_new : mem_q[rd_bank_i][rd_addr_i];
`else
  assign rd_word = mem_q[rd_bank_i][rd_addr_i];
`endif

  assign rd_data_d = !rd_req_i           ? rd_data_q :
                     bank_ok(rd_bank_i)  ? rd_word   : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    sdata_d = sdata_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (strm_start_i && bank_ok(strm_bank_i)) begin
          state_d = S_STRM;
          cnt_d   = '0;
          bank_d  = strm_bank_i;
          sdata_d = mem_q[strm_bank_i][ZERO];
        end else if (clr_start_i && bank_ok(clr_bank_i)) begin
          state_d = S_CLR;
          cnt_d   = '0;
          bank_d  = clr_bank_i;
        end
      end
      (state_q == S_STRM): begin
        if (strm_ready_i) begin
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_nxt;
            sdata_d = mem_q[bank_q][cnt_nxt];
          end
        end
      end
      (state_q == S_CLR): begin
        if (cnt_q == LAST) state_d = S_IDLE;
        else cnt_d = cnt_nxt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bank_q     <= '0;
      sdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      sdata_q    <= sdata_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_CLR) mem_q[bank_q][cnt_q] <= '0;
    if (wr_ok) mem_q[wr_bank_i][wr_addr_i] <= wr_new;
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign strm_data_o  = sdata_q;
  assign strm_valid_o = (state_q == S_STRM);
  assign strm_last_o  = (state_q == S_STRM) && (cnt_q == LAST);
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_scrachpad_banked_stream.sv
// Bench for scrachpad_banked_stream: vector table, directed stream/clear/reset
// sequences and a random run against a behavioural scratchpad model.
module tb_scrachpad_banked_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [1:0]  rd_bank;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        strm_start;
  logic [1:0]  strm_bank;
  logic [31:0] strm_data;
  logic        strm_valid;
  logic        strm_ready;
  logic        strm_last;
  logic        clr_start;
  logic [1:0]  clr_bank;
  logic        busy;

  scrachpad_banked_stream dut (
    .clk_i(clk), .reset_ni(rst_n),
    .wr_en_i(wr_en), .wr_bank_i(wr_bank), .wr_addr_i(wr_addr),
    .wr_strb_i(wr_strb), .wr_data_i(wr_data),
    .rd_req_i(rd_req), .rd_bank_i(rd_bank), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .strm_start_i(strm_start), .strm_bank_i(strm_bank),
    .strm_data_o(strm_data), .strm_valid_o(strm_valid),
    .strm_ready_i(strm_ready), .strm_last_o(strm_last),
    .clr_start_i(clr_start), .clr_bank_i(clr_bank), .busy_o(busy)
  );

  int nvec = 0;
  int nerr = 0;

  // model: memory image plus engine mode (0 idle, 1 stream, 2 clear)
  logic [31:0] m [4][16];
  logic [1:0]  e_mode;
  logic [3:0]  e_idx;
  logic [1:0]  e_bank;
  logic [31:0] e_word;
  logic [31:0] e_rdd;
  logic        e_rdv;
  logic [32:0] q [$];

  typedef struct {
    bit          we;
    logic [1:0]  b;
    logic [3:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
    bit          re;
    bit          ck;
    logic [31:0] ex;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_bank = 0; wr_addr = 0; wr_strb = 0; wr_data = 0;
    rd_req = 0; rd_bank = 0; rd_addr = 0;
    strm_start = 0; strm_bank = 0; clr_start = 0; clr_bank = 0;
  endtask

  task automatic step();
    logic [31:0] mg;
    bit acc;
    acc = wr_en && !(e_mode == 2 && wr_bank == e_bank);
    mg = m[wr_bank][wr_addr];
    for (int k = 0; k < 4; k++)
      if (wr_strb[k]) mg[k*8 +: 8] = wr_data[k*8 +: 8];
    e_rdv = rd_req;
    if (rd_req) begin
      e_rdd = m[rd_bank][rd_addr];
`ifdef SP_RD_BYPASS_EN
      if (acc && rd_bank == wr_bank && rd_addr == wr_addr) e_rdd = mg;
`endif
    end
    if (e_mode == 0) begin
      if (strm_start) begin
        e_mode = 1; e_idx = 0; e_bank = strm_bank;
        e_word = m[strm_bank][0];
      end else if (clr_start) begin
        e_mode = 2; e_idx = 0; e_bank = clr_bank;
      end
    end else if (e_mode == 1) begin
      if (strm_ready) begin
        if (e_idx == 4'd15) e_mode = 0;
        else begin e_idx++; e_word = m[e_bank][e_idx]; end
      end
    end else begin
      m[e_bank][e_idx] = 0;
      if (e_idx == 4'd15) e_mode = 0;
      else e_idx++;
    end
    if (acc) m[wr_bank][wr_addr] = mg;
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, e_rdv);
    chk("rd_data", rd_data, e_rdd);
    chk("strm_valid", strm_valid, e_mode == 1);
    if (e_mode == 1) chk("strm_data", strm_data, e_word);
    chk("strm_last", strm_last, e_mode == 1 && e_idx == 4'd15);
    chk("busy", busy, e_mode != 0);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin step(); c++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] a,
                    input logic [3:0] s, input logic [31:0] d);
    wr_en = 1; wr_bank = b; wr_addr = a; wr_strb = s; wr_data = d;
    step();
    idle();
  endtask

  task automatic rd(input logic [1:0] b, input logic [3:0] a);
    rd_req = 1; rd_bank = b; rd_addr = a;
    step();
    idle();
  endtask

  task automatic run_stream(input logic [1:0] b, input bit stall);
    q.delete();
    strm_start = 1; strm_bank = b;
    step();
    idle();
    for (int c = 0; c < 80 && strm_valid; c++) begin
      strm_ready = stall ? (c % 3 == 0) : 1'b1;
      if (strm_ready) q.push_back({strm_last, strm_data});
      step();
    end
    strm_ready = 0;
    chk("strm_count", q.size(), 16);
    for (int i = 0; i < q.size(); i++) begin
      chk("strm_word", q[i][31:0], i + 1);
      chk("strm_lastflag", q[i][32], i == 15);
    end
    chk("strm_busy_after", busy, 0);
  endtask

  task automatic out_zero(input string n);
    chk({n, "_rd_valid"}, rd_valid, 0);
    chk({n, "_rd_data"}, rd_data, 0);
    chk({n, "_strm_valid"}, strm_valid, 0);
    chk({n, "_strm_data"}, strm_data, 0);
    chk({n, "_strm_last"}, strm_last, 0);
    chk({n, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] exp6;
    idle();
    strm_ready = 0;
    e_mode = 0; e_idx = 0; e_bank = 0; e_word = 0;
    e_rdd = 0; e_rdv = 0;
    #12;
    out_zero("reset");
    @(negedge clk);
    rst_n = 1;

    for (int b = 0; b < 4; b++) begin
      clr_start = 1; clr_bank = 2'(b);
      step();
      idle();
      wait_idle(40);
    end

    tbl[0]  = '{1, 2'd2, 4'd5,  4'hF, 32'hA1B2C3D4, 0, 0, 32'h0};
    tbl[1]  = '{0, 2'd2, 4'd5,  4'h0, 32'h0,        1, 1, 32'hA1B2C3D4};
    tbl[2]  = '{1, 2'd2, 4'd6,  4'hF, 32'h11223344, 0, 0, 32'h0};
    tbl[3]  = '{1, 2'd2, 4'd6,  4'h5, 32'hFFFFFFFF, 0, 0, 32'h0};
    tbl[4]  = '{0, 2'd2, 4'd6,  4'h0, 32'h0,        1, 1, 32'h11FF33FF};
    tbl[5]  = '{1, 2'd3, 4'd0,  4'h8, 32'hDEADBEEF, 0, 0, 32'h0};
    tbl[6]  = '{0, 2'd3, 4'd0,  4'h0, 32'h0,        1, 1, 32'hDE000000};
    tbl[7]  = '{1, 2'd0, 4'd15, 4'hF, 32'hCAFEF00D, 0, 0, 32'h0};
    tbl[8]  = '{1, 2'd0, 4'd15, 4'h1, 32'h12345678, 0, 0, 32'h0};
    tbl[9]  = '{0, 2'd0, 4'd15, 4'h0, 32'h0,        1, 1, 32'hCAFEF078};
    tbl[10] = '{0, 2'd2, 4'd5,  4'h0, 32'h0,        1, 1, 32'hA1B2C3D4};
    for (int i = 0; i < 11; i++) begin
      wr_en = tbl[i].we; wr_bank = tbl[i].b; wr_addr = tbl[i].a;
      wr_strb = tbl[i].s; wr_data = tbl[i].d;
      rd_req = tbl[i].re; rd_bank = tbl[i].b; rd_addr = tbl[i].a;
      step();
      idle();
      if (tbl[i].ck) begin
        chk("tbl_rd_valid", rd_valid, 1);
        chk("tbl_rd_data", rd_data, tbl[i].ex);
      end
    end

    for (int n = 0; n < 16; n++) wr(2'd1, 4'(n), 4'hF, 32'(n + 1));
    run_stream(2'd1, 0);
    run_stream(2'd1, 1);

    for (int n = 0; n < 16; n++) wr(2'd0, 4'(n), 4'hF, 32'hF0F00000 + n);
    clr_start = 1; clr_bank = 0;
    step();
    idle();
    step();
    wr_en = 1; wr_bank = 0; wr_addr = 3; wr_strb = 4'hF;
    wr_data = 32'h33333333;
    step();
    idle();
    wr_en = 1; wr_bank = 3; wr_addr = 3; wr_strb = 4'hF;
    wr_data = 32'h44444444;
    strm_start = 1; strm_bank = 1; strm_ready = 1;
    step();
    idle();
    chk("clr_no_stream", strm_valid, 0);
    chk("clr_busy", busy, 1);
    strm_ready = 0;
    wait_idle(40);
    for (int n = 0; n < 16; n++) begin
      rd(2'd0, 4'(n));
      chk("clr_zero", rd_data, 0);
    end
    rd(2'd3, 4'd3);
    chk("clr_other_bank", rd_data, 32'h44444444);

`ifdef SP_RD_BYPASS_EN
    exp6 = 32'h5A5A5A5A;
`else
    exp6 = 32'h0;
`endif
    wr_en = 1; wr_bank = 0; wr_addr = 7; wr_strb = 4'hF;
    wr_data = 32'h5A5A5A5A;
    rd_req = 1; rd_bank = 0; rd_addr = 7;
    step();
    idle();
    chk("same_cycle_rd", rd_data, exp6);
    rd(2'd0, 4'd7);
    chk("after_write_rd", rd_data, 32'h5A5A5A5A);

    strm_start = 1; strm_bank = 1; strm_ready = 1;
    rd_req = 1; rd_bank = 2; rd_addr = 5;
    step();
    idle();
    step();
    step();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1 out_zero("midrst");
    e_mode = 0; e_rdv = 0; e_rdd = 0;
    strm_ready = 0;
    @(negedge clk);
    rst_n = 1;
    step();

    for (int c = 0; c < 800; c++) begin
      wr_en = ($urandom_range(1) == 1);
      wr_bank = 2'($urandom_range(3));
      wr_addr = 4'($urandom_range(15));
      wr_strb = 4'($urandom_range(15));
      wr_data = $urandom;
      rd_req = ($urandom_range(1) == 1);
      rd_bank = 2'($urandom_range(3));
      rd_addr = 4'($urandom_range(15));
      strm_start = ($urandom_range(7) == 0);
      strm_bank = 2'($urandom_range(3));
      clr_start = ($urandom_range(11) == 0);
      clr_bank = 2'($urandom_range(3));
      strm_ready = ($urandom_range(9) < 7);
      step();
    end
    idle();
    strm_ready = 1;
    wait_idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
